// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package : arm_mem_pkg
//  Shared encodings for the unified-memory port arbiter: FSM states,
//  requester (owner) encoding, full-word byte enable and wait counter width.
//  Revision: 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam int         WAIT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arb_pick
//  Combinational winner select between the fetch and data requesters.
//  A lone request always wins. Contests go to DATA, or, when ROUND_ROBIN_EN
//  is defined, to whichever owner did not win the previous capture.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import arm_mem_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
    input  owner_t last_owner,
    output owner_t grant,
    output logic   any
);

    owner_t w_contest_winner;

    assign any = inst_req | data_req;

`ifdef ROUND_ROBIN_EN
    assign w_contest_winner = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
    // Fixed priority: history is irrelevant, data always takes a contest
    logic w_unused_last_owner;
    assign w_unused_last_owner = last_owner;
    assign w_contest_winner    = OWN_DATA;
`endif

    // Single requester wins outright; both requesting falls to the contest rule
    always_comb begin
        grant = OWN_INST;
        if (data_req && !inst_req) begin
            grant = OWN_DATA;
        end else if (data_req && inst_req) begin
            grant = w_contest_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mem_port_arbiter
//  Shares a single-ported unified memory between the instruction-fetch and
//  load/store requesters: arbitrate in IDLE, run a WAIT_STATES+1 cycle
//  access, then pulse the owner's valid for one cycle in RESP.
//  Build option: ROUND_ROBIN_EN selects alternating contest winners instead
//  of fixed data priority.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_port_arbiter: WAIT_STATES must be 0..15");
    end
    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_port_arbiter: DATA_W must be 32");
    end

    localparam logic [WAIT_CNT_W-1:0] c_wait_init = WAIT_CNT_W'(WAIT_STATES);

    state_t                r_state;
    owner_t                r_owner;
    logic                  r_first;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [3:0]            r_be;
    logic [DATA_W-1:0]     r_i_rdata;
    logic [DATA_W-1:0]     r_d_rdata;

    owner_t w_grant;
    owner_t w_last_owner;
    logic   w_any;

    // Fetches are always word reads, so the byte offset is dropped
    logic w_unused_fetch_lsbs;
    assign w_unused_fetch_lsbs = ^i_addr[1:0];

    mem_arb_pick u_pick (
        .inst_req   (i_req),
        .data_req   (d_req),
        .last_owner (w_last_owner),
        .grant      (w_grant),
        .any        (w_any)
    );

`ifdef ROUND_ROBIN_EN
    owner_t r_last_owner;

    // Remember the winner of every capture so the next contest alternates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= OWN_INST;
        end else if (r_state == ST_IDLE && w_any) begin
            r_last_owner <= w_grant;
        end
    end

    assign w_last_owner = r_last_owner;
`else
    assign w_last_owner = OWN_INST;
`endif

    // Arbitrate and latch in IDLE, count out the access, then respond for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_INST;
            r_first   <= 1'b0;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_grant;
                        r_first <= 1'b1;
                        r_cnt   <= c_wait_init;
                        r_state <= ST_ACCESS;
                        if (w_grant == OWN_DATA) begin
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_be    <= d_be;
                        end else begin
                            r_we    <= 1'b0;
                            r_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            r_wdata <= '0;
                            r_be    <= BE_WORD;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_first <= 1'b0;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - WAIT_CNT_W'(1);
                    end else begin
                        // Stores leave both read-data registers untouched
                        if (!r_we) begin
                            if (r_owner == OWN_DATA) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state registers so reset clears them at once
    assign busy      = (r_state != ST_IDLE);
    assign mem_cs    = (r_state == ST_ACCESS);
    assign mem_we    = mem_cs & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

    assign i_gnt   = mem_cs & r_first & (r_owner == OWN_INST);
    assign d_gnt   = mem_cs & r_first & (r_owner == OWN_DATA);
    assign i_valid = (r_state == ST_RESP) & (r_owner == OWN_INST);
    assign d_valid = (r_state == ST_RESP) & (r_owner == OWN_DATA);
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_mem_port_arbiter
//  Self-checking bench: directed cases plus randomized requesters, compared
//  every cycle against a transaction-level model (phase since capture,
//  expected memory image, expected read-data registers).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int WS = 2;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_gnt, i_valid, d_gnt, d_valid, mem_cs, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.WAIT_STATES(WS), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        if (k == 65) return 32'hE3A01005;  // word at byte address 0x104
        return (32'(k) * 32'h01010101) ^ 32'hA5A5A5A5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // Memory macro stand-in, driven purely by the DUT's memory port
    logic [31:0] mac_mem [256];
    assign mem_rdata = mac_mem[mem_addr[9:2]];
    initial begin
        for (int k = 0; k < 256; k++) mac_mem[k] = init_word(k);
        forever begin
            @(negedge clk);
            if (mem_cs && mem_we) mac_mem[mem_addr[9:2]] = merge(mac_mem[mem_addr[9:2]], mem_wdata, mem_be);
        end
    end

    // Reference model: phase = cycles since the capture edge (0 = idle)
    int          m_phase;
    bit          m_own_d, m_last_d, m_we;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;
    logic [3:0]  m_be;
    logic [31:0] m_mem [256];
    initial begin
        for (int k = 0; k < 256; k++) m_mem[k] = init_word(k);
        m_phase = 0; m_own_d = 0; m_last_d = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_be = '0; m_ird = '0; m_drd = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_phase = 0; m_last_d = 0; m_ird = '0; m_drd = '0;
            end else if (m_phase == 0) begin
                if (i_req || d_req) begin
                    if (i_req && d_req) m_own_d = RR ? !m_last_d : 1'b1;
                    else                m_own_d = d_req;
                    m_last_d = m_own_d;
                    if (m_own_d) begin
                        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
                    end else begin
                        m_we = 0; m_addr = i_addr & 32'hFFFF_FFFC; m_wdata = '0; m_be = 4'hF;
                    end
                    m_phase = 1;
                end
            end else if (m_phase == WS + 2) begin
                m_phase = 0;
            end else begin
                if (m_phase == WS + 1) begin
                    if (m_we)         m_mem[m_addr[9:2]] = merge(m_mem[m_addr[9:2]], m_wdata, m_be);
                    else if (m_own_d) m_drd = m_mem[m_addr[9:2]];
                    else              m_ird = m_mem[m_addr[9:2]];
                end
                m_phase++;
            end
        end
    end

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        logic exp_cs;
        exp_cs = (m_phase >= 1) && (m_phase <= WS + 1);
        chk("busy",    busy,    m_phase != 0);
        chk("mem_cs",  mem_cs,  exp_cs);
        chk("mem_we",  mem_we,  exp_cs && m_we);
        chk("i_gnt",   i_gnt,   (m_phase == 1) && !m_own_d);
        chk("d_gnt",   d_gnt,   (m_phase == 1) && m_own_d);
        chk("i_valid", i_valid, (m_phase == WS + 2) && !m_own_d);
        chk("d_valid", d_valid, (m_phase == WS + 2) && m_own_d);
        chk("i_rdata", i_rdata, m_ird);
        chk("d_rdata", d_rdata, m_drd);
        if (exp_cs) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_be",   mem_be,   m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic wait_valid(input bit want_d, input string name, output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            got = want_d ? d_valid : i_valid;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: no valid after %0d cycles, expected within %0d", name, cyc, WS + 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nv, guard, iw, dw;
        bit order [3];

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 0);       chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_be", mem_be, 0);
        chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Store 0xDEADBEEF to 0x200, then load it back
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        for (int c = 1; c <= WS + 2; c++) begin
            @(negedge clk);
            chk("st_d_gnt",   d_gnt,   c == 1);
            chk("st_mem_we",  mem_we,  c <= WS + 1);
            chk("st_d_valid", d_valid, c == WS + 2);
            if (c <= WS + 1) begin
                chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
                chk("st_mem_addr",  mem_addr,  32'h200);
            end
        end
        chk("st_d_rdata", d_rdata, 32'h0);
        d_req = 0;
        @(negedge clk);
        d_req = 1; d_we = 0;
        wait_valid(1, "ld", cyc);
        chk("ld_latency", cyc, WS + 2);
        chk("ld_d_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 0;
        @(negedge clk);

        // Fetch 0x104, exact cycle-by-cycle timing
        i_req = 1; i_addr = 32'h104;
        for (int c = 1; c <= WS + 2; c++) begin
            @(negedge clk);
            chk("f1_i_gnt",   i_gnt,   c == 1);
            chk("f1_mem_cs",  mem_cs,  c <= WS + 1);
            chk("f1_i_valid", i_valid, c == WS + 2);
            chk("f1_d_valid", d_valid, 0);
        end
        chk("f1_i_rdata", i_rdata, 32'hE3A01005);
        i_req = 0;
        @(negedge clk);

        // Unaligned fetch address is word-aligned on the memory port
        i_req = 1; i_addr = 32'h107;
        @(negedge clk);
        chk("f5_mem_addr", mem_addr, 32'h104);
        chk("f5_mem_be",   mem_be,   4'hF);
        chk("f5_mem_we",   mem_we,   0);
        wait_valid(0, "f5", cyc);
        chk("f5_i_rdata", i_rdata, 32'hE3A01005);
        i_req = 0;
        @(negedge clk);

        // Three back-to-back contests with both requests held
        i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h80; d_be = 4'hF;
        nv = 0; guard = 0;
        while (nv < 3 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (d_valid)      begin order[nv] = 1; nv++; end
            else if (i_valid) begin order[nv] = 0; nv++; end
        end
        d_req = 0;
        chk("contest_count", nv, 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("contest_%0d_is_data", k), order[k], (k == 1 && RR) ? 0 : 1);
        wait_valid(0, "contest_drain", cyc);
        i_req = 0;
        @(negedge clk);

        // Reset in the second ACCESS cycle of a fetch, request held across it
        i_req = 1; i_addr = 32'h40;
        @(negedge clk);
        chk("rs_i_gnt", i_gnt, 1);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("rs_mem_cs", mem_cs, 0);
        chk("rs_busy",   busy,   0);
        chk("rs_i_valid", i_valid, 0);
        @(negedge clk); @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rs_regnt", i_gnt, 1);
        wait_valid(0, "rs", cyc);
        chk("rs_latency", cyc, WS + 1);
        chk("rs_i_rdata", i_rdata, init_word(16));
        i_req = 0;
        @(negedge clk);

        // Randomized requesters honouring the hold-until-valid handshake
        iw = 0; dw = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (i_req) begin
                if (i_valid) i_req = 0;
                else begin
                    if (i_gnt) i_addr = $urandom;
                    iw++;
                    if (iw > 200) begin
                        n_tests++; n_fail++; i_req = 0;
                        $display("FAIL rand_fetch_timeout: waited %0d cycles, expected valid", iw);
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom_range(0, 1023); iw = 0;
            end
            if (d_req) begin
                if (d_valid) d_req = 0;
                else begin
                    if (d_gnt) begin
                        d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
                    end
                    dw++;
                    if (dw > 200) begin
                        n_tests++; n_fail++; d_req = 0;
                        $display("FAIL rand_data_timeout: waited %0d cycles, expected valid", dw);
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom); d_addr = {22'd0, 8'($urandom), 2'b00};
                d_wdata = $urandom; d_be = 4'($urandom); dw = 0;
            end
        end
        i_req = 0; d_req = 0;
        repeat (WS + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
